// File: rtl/mux8_scan_ctrl.sv
// Round-robin scanner for an 8:1 mux: selects a requesting channel, waits a
// programmable settle time, captures the mux byte and offers it on valid/ready.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | not scanning; sel keeps its last value
// SETTLE | sel driven to the committed channel, dwell counter running
// HOLD   | captured byte presented, waiting for out_ready
module mux8_scan_ctrl #(
    parameter int DW    = 8,
    parameter int DWELL = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic [7:0]    req,
    input  logic [DW-1:0] mux_y,
    output logic [2:0]    sel,
    output logic [DW-1:0] out_data,
    output logic [2:0]    out_ch,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(DWELL - 1);

    state_t        state_q, state_d;
    logic [3:0]    cnt_q,   cnt_d;
    logic [2:0]    ptr_q,   ptr_d;
    logic [2:0]    sel_q,   sel_d;
    logic [DW-1:0] data_q,  data_d;
    logic [2:0]    ch_q,    ch_d;
    logic          valid_q, valid_d;

    logic [2:0]    pick_ch;
    logic          pick_found;
    logic [2:0]    pick_idx;

    // Search starts just after the last-served channel; i=8 wraps onto ptr itself.
    always_comb begin
        pick_ch    = ptr_q;
        pick_found = 1'b0;
        pick_idx   = 3'd0;
        for (int i = 1; i <= 8; i++) begin
            pick_idx = ptr_q + 3'(i);
            if (!pick_found && req[pick_idx]) begin
                pick_ch    = pick_idx;
                pick_found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        data_d  = data_q;
        ch_d    = ch_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (en && (req != 8'd0)) begin
                    sel_d   = pick_ch;
                    cnt_d   = CNT_INIT;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    data_d  = mux_y;
                    ch_d    = sel_q;
                    valid_d = 1'b1;
                    ptr_d   = sel_q;
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (valid_q && out_ready) begin
                    valid_d = 1'b0;
                    if (en && (req != 8'd0)) begin
                        sel_d   = pick_ch;
                        cnt_d   = CNT_INIT;
                        state_d = SETTLE;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            ptr_q   <= 3'd7;
            sel_q   <= 3'd0;
            data_q  <= '0;
            ch_q    <= 3'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            ch_q    <= ch_d;
            valid_q <= valid_d;
        end
    end

    assign sel       = sel_q;
    assign out_data  = data_q;
    assign out_ch    = ch_q;
    assign out_valid = valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mux8_scan_ctrl.sv
// Directed bench for mux8_scan_ctrl: one instance with DWELL=1, one with DWELL=4.
module tb_mux8_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       en_a = 1'b0, ready_a = 1'b0, use_model_a = 1'b0;
    logic [7:0] req_a = 8'd0, muxv_a = 8'd0, mux_y_a, data_a;
    logic [2:0] sel_a, ch_a;
    logic       valid_a, busy_a;

    logic       en_b = 1'b0, ready_b = 1'b0;
    logic [7:0] req_b = 8'd0, muxv_b = 8'd0, data_b;
    logic [2:0] sel_b, ch_b;
    logic       valid_b, busy_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Behavioural mux: channel i drives 8'h10+i when the model is enabled.
    assign mux_y_a = use_model_a ? (8'h10 + {5'd0, sel_a}) : muxv_a;

    mux8_scan_ctrl #(.DW(8), .DWELL(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .en(en_a), .req(req_a), .mux_y(mux_y_a),
        .sel(sel_a), .out_data(data_a), .out_ch(ch_a), .out_valid(valid_a),
        .out_ready(ready_a), .busy(busy_a)
    );

    mux8_scan_ctrl #(.DW(8), .DWELL(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .en(en_b), .req(req_b), .mux_y(muxv_b),
        .sel(sel_b), .out_data(data_b), .out_ch(ch_b), .out_valid(valid_b),
        .out_ready(ready_b), .busy(busy_b)
    );

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if (sel_a !== 3'd0) begin n_fail++; $display("FAIL reset_sel got=%0d exp=0", sel_a); end
        n_checks++; if (data_a !== 8'h00) begin n_fail++; $display("FAIL reset_data got=%h exp=00", data_a); end
        n_checks++; if (ch_a !== 3'd0) begin n_fail++; $display("FAIL reset_ch got=%0d exp=0", ch_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", valid_a); end
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy_a); end
        n_checks++; if ({valid_b, busy_b, sel_b} !== 5'd0) begin n_fail++; $display("FAIL reset_b got=%b exp=00000", {valid_b, busy_b, sel_b}); end
        rst_n = 1'b1;
    endtask

    task automatic test_single();
        @(negedge clk);
        en_a = 1'b1; req_a = 8'h01; muxv_a = 8'hA5; ready_a = 1'b1; use_model_a = 1'b0;
        @(negedge clk);
        n_checks++; if (sel_a !== 3'd0) begin n_fail++; $display("FAIL single_sel got=%0d exp=0", sel_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_settle got=%b exp=1", busy_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL single_valid_early got=%b exp=0", valid_a); end
        @(negedge clk);
        n_checks++; if (valid_a !== 1'b1) begin n_fail++; $display("FAIL single_valid got=%b exp=1", valid_a); end
        n_checks++; if (data_a !== 8'hA5) begin n_fail++; $display("FAIL single_data got=%h exp=a5", data_a); end
        n_checks++; if (ch_a !== 3'd0) begin n_fail++; $display("FAIL single_ch got=%0d exp=0", ch_a); end
        n_checks++; if (busy_a !== 1'b1) begin n_fail++; $display("FAIL single_busy_hold got=%b exp=1", busy_a); end
        en_a = 1'b0;
        @(negedge clk);
        n_checks++; if ({valid_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL single_idle got=%b exp=00", {valid_a, busy_a}); end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp_ch [5];
        exp_ch = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2};
        apply_reset();
        en_a = 1'b1; req_a = 8'b1000_0101; use_model_a = 1'b1; ready_a = 1'b1;
        for (int k = 0; k < 5; k++) begin
            int t;
            t = 0;
            do begin
                @(negedge clk);
                t++;
                n_checks++;
                if (sel_a == 3'd1 || (sel_a >= 3'd3 && sel_a <= 3'd6)) begin
                    n_fail++; $display("FAIL rr_sel_idle_channel got=%0d exp=0/2/7", sel_a);
                end
            end while (!valid_a && t < 10);
            n_checks++;
            if (valid_a !== 1'b1) begin
                n_fail++; $display("FAIL rr_timeout sample=%0d got=no valid exp=valid", k);
            end else begin
                n_checks++; if (t !== 2) begin n_fail++; $display("FAIL rr_period sample=%0d got=%0d exp=2", k, t); end
                n_checks++; if (ch_a !== exp_ch[k]) begin n_fail++; $display("FAIL rr_ch sample=%0d got=%0d exp=%0d", k, ch_a, exp_ch[k]); end
                n_checks++; if (data_a !== (8'h10 + {5'd0, exp_ch[k]})) begin n_fail++; $display("FAIL rr_data sample=%0d got=%h exp=%h", k, data_a, 8'h10 + {5'd0, exp_ch[k]}); end
            end
        end
        en_a = 1'b0;
        @(negedge clk);
        n_checks++; if ({valid_a, busy_a} !== 2'b00) begin n_fail++; $display("FAIL rr_idle got=%b exp=00", {valid_a, busy_a}); end
    endtask

    task automatic test_dwell();
        logic [7:0] junk [4];
        junk = '{8'h22, 8'h33, 8'h44, 8'hC3};
        @(negedge clk);
        en_b = 1'b1; req_b = 8'h08; muxv_b = 8'h11; ready_b = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_checks++; if (sel_b !== 3'd3) begin n_fail++; $display("FAIL dwell_sel cycle=%0d got=%0d exp=3", k, sel_b); end
            n_checks++; if ({valid_b, busy_b} !== 2'b01) begin n_fail++; $display("FAIL dwell_state cycle=%0d got=%b exp=01", k, {valid_b, busy_b}); end
            muxv_b = junk[k];
        end
        @(negedge clk);
        n_checks++; if (valid_b !== 1'b1) begin n_fail++; $display("FAIL dwell_valid got=%b exp=1", valid_b); end
        n_checks++; if (data_b !== 8'hC3) begin n_fail++; $display("FAIL dwell_data got=%h exp=c3", data_b); end
        n_checks++; if (ch_b !== 3'd3) begin n_fail++; $display("FAIL dwell_ch got=%0d exp=3", ch_b); end
        en_b = 1'b0;
        @(negedge clk);
        n_checks++; if ({valid_b, busy_b} !== 2'b00) begin n_fail++; $display("FAIL dwell_idle got=%b exp=00", {valid_b, busy_b}); end
    endtask

    task automatic test_backpressure();
        // ptr is 2 after the round-robin run, so ch4 comes before ch5.
        @(negedge clk);
        en_a = 1'b1; req_a = 8'h30; use_model_a = 1'b1; ready_a = 1'b0;
        @(negedge clk);
        n_checks++; if (sel_a !== 3'd4) begin n_fail++; $display("FAIL bp_sel got=%0d exp=4", sel_a); end
        @(negedge clk);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if ({valid_a, data_a, ch_a, sel_a} !== {1'b1, 8'h14, 3'd4, 3'd4}) begin
                n_fail++; $display("FAIL bp_hold cycle=%0d got=v%b d%h c%0d s%0d exp=v1 d14 c4 s4", k, valid_a, data_a, ch_a, sel_a);
            end
            @(negedge clk);
        end
        ready_a = 1'b1;
        @(negedge clk);
        n_checks++; if ({valid_a, sel_a} !== {1'b0, 3'd5}) begin n_fail++; $display("FAIL bp_release got=v%b s%0d exp=v0 s5", valid_a, sel_a); end
        @(negedge clk);
        n_checks++; if ({valid_a, ch_a, data_a} !== {1'b1, 3'd5, 8'h15}) begin n_fail++; $display("FAIL bp_next got=v%b c%0d d%h exp=v1 c5 d15", valid_a, ch_a, data_a); end
        en_a = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL bp_idle got=%b exp=0", busy_a); end
    endtask

    task automatic test_drop();
        // ptr is 5; a lone ch5 request must be re-served.
        @(negedge clk);
        en_a = 1'b1; req_a = 8'h20; use_model_a = 1'b1; ready_a = 1'b0;
        @(negedge clk);
        n_checks++; if ({busy_a, sel_a} !== {1'b1, 3'd5}) begin n_fail++; $display("FAIL drop_settle got=b%b s%0d exp=b1 s5", busy_a, sel_a); end
        req_a = 8'h00; en_a = 1'b0;
        @(negedge clk);
        n_checks++; if ({valid_a, ch_a, data_a} !== {1'b1, 3'd5, 8'h15}) begin n_fail++; $display("FAIL drop_deliver got=v%b c%0d d%h exp=v1 c5 d15", valid_a, ch_a, data_a); end
        ready_a = 1'b1;
        @(negedge clk);
        n_checks++; if ({valid_a, busy_a, sel_a} !== {1'b0, 1'b0, 3'd5}) begin n_fail++; $display("FAIL drop_idle got=v%b b%b s%0d exp=v0 b0 s5", valid_a, busy_a, sel_a); end
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL drop_stays_idle got=%b exp=0", busy_a); end
    endtask

    task automatic test_reset_hold();
        @(negedge clk);
        en_a = 1'b1; req_a = 8'h04; use_model_a = 1'b1; ready_a = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++; if ({valid_a, ch_a, data_a} !== {1'b1, 3'd2, 8'h12}) begin n_fail++; $display("FAIL rsth_pre got=v%b c%0d d%h exp=v1 c2 d12", valid_a, ch_a, data_a); end
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if ({valid_a, data_a, sel_a, ch_a, busy_a} !== 15'd0) begin n_fail++; $display("FAIL rsth_async got=v%b d%h s%0d c%0d b%b exp=all 0", valid_a, data_a, sel_a, ch_a, busy_a); end
        req_a = 8'h05;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if ({valid_a, sel_a} !== {1'b0, 3'd0}) begin n_fail++; $display("FAIL rsth_restart_sel got=v%b s%0d exp=v0 s0", valid_a, sel_a); end
        @(negedge clk);
        n_checks++; if ({valid_a, ch_a, data_a} !== {1'b1, 3'd0, 8'h10}) begin n_fail++; $display("FAIL rsth_restart got=v%b c%0d d%h exp=v1 c0 d10", valid_a, ch_a, data_a); end
        en_a = 1'b0; ready_a = 1'b1;
        @(negedge clk);
        n_checks++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL rsth_idle got=%b exp=0", busy_a); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_dwell();
        test_backpressure();
        test_drop();
        test_reset_hold();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux8_scan_ctrl.md
Name: mux8_scan_ctrl

Overview:
- Round-robin channel scanner that sits directly in front of the 8-channel, 8-bit-per-channel mux.
- Drives the mux select lines {s2,s1,s0} and waits a programmable settle time.
- Captures the mux output byte and hands it downstream, tagged with its channel number, over a valid/ready handshake.
- Only channels with an active request bit are visited; idle channels are skipped.

Parameters:
- DW, 8, data width of the mux output and the captured byte.
- DWELL, 1, cycles the select is held stable before capture. Legal range 1..15; 4-bit counter.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- en  in  1  scan enable; sampled only in IDLE and at handshake completion.
- req  in  8  per-channel request mask; bit i set means channel i is eligible.
- mux_y  in  DW  output of the 8:1 mux.
- sel  out  3  channel select to the mux: sel[2]=s2, sel[1]=s1, sel[0]=s0.
- out_data  out  DW  captured byte.
- out_ch  out  3  channel number of out_data.
- out_valid  out  1  out_data/out_ch valid.
- out_ready  in  1  downstream accepts the sample when high with out_valid.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, immediate on rst_n low):
  - sel=0, out_data=0, out_ch=0, out_valid=0, busy=0.
  - state=IDLE, dwell counter=0, last-served pointer ptr=7, so the first search starts at channel 0.
- Channel pick:
  - ch = first set bit of req, scanning ptr+1, ptr+2, ... modulo 8.
  - ptr itself is checked last, so a lone requester is re-served.
  - The pick uses the req value present in the cycle the pick is made.
- States: IDLE, SETTLE, HOLD.
- IDLE:
  - If en=1 and req!=0: sel<=ch, cnt<=DWELL-1, go to SETTLE.
  - Otherwise stay in IDLE; sel keeps its last value.
- SETTLE:
  - sel is held constant.
  - If cnt!=0: cnt<=cnt-1.
  - If cnt==0:
    - out_data<=mux_y, out_ch<=sel, out_valid<=1, ptr<=sel.
    - Go to HOLD.
- HOLD:
  - out_valid, out_data and out_ch are held stable until out_ready=1.
  - On an edge where out_valid=1 and out_ready=1:
    - out_valid<=0.
    - If en=1 and req!=0: pick the next channel (using the updated ptr), sel<=ch, cnt<=DWELL-1, go to SETTLE.
    - Otherwise go to IDLE.
- Latency with DWELL=D and out_ready tied high:
  - Request to out_valid = D+1 cycles.
  - Back-to-back samples every D+1 cycles; out_valid is low for D cycles between samples.
- sel changes only on entry to SETTLE. It is never glitched while a capture is pending.
- Boundary conditions:
  - req bit drops during SETTLE: the committed channel is still captured and delivered.
  - req becomes all zeros during HOLD: the transfer completes, then IDLE.
  - en drops mid-operation: the current transfer completes; no new pick; then IDLE.
  - out_ready high while out_valid low: ignored.
  - out_ready held low: HOLD indefinitely; no data loss; no select change.
  - Wrap-around: ptr=7 with req bit 0 set picks channel 0.
  - rst_n asserted mid-SETTLE or mid-HOLD: outputs clear at once. The pending sample is discarded, not delivered.

Test Plan:
- Reset, then en=1, req=8'h01, mux_y=8'hA5, DWELL=1, out_ready=1 -> sel=0 one edge after the pick; out_valid=1 with out_data=A5, out_ch=0 two cycles after req; busy high throughout.
- req=8'b1000_0101, out_ready=1, mux_y modelled as 8 distinct bytes (channel i drives 8'h10+i) -> captured order is ch0, ch2, ch7, ch0, ...; out_data=10, 12, 17, 10; channels 1 and 3-6 are never selected.
- DWELL=4, single channel 3 -> sel=3 held for 4 cycles before capture; out_valid appears 5 cycles after the pick; changing mux_y during the dwell cycles has no effect, only the value on the final dwell cycle is captured.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> out_valid stays high; out_data, out_ch and sel stay constant; release out_ready -> next channel is picked on the handshake edge.
- req cleared and en=0 during SETTLE for channel 5 -> sample from ch5 is still delivered; after the handshake, state=IDLE and busy=0.
- rst_n pulsed low while in HOLD with out_valid=1 -> out_valid, out_data and sel go to 0 asynchronously; after release, scanning restarts from channel 0.
